// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog.
// master: drives en, div_n, div_load; observes the divider outputs.
// slave : the divider itself.
interface clk_div_prog_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned OUT_W = 2
);
    logic             en;
    logic [CNT_W-1:0] div_n;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             ce_rise;
    logic             ce_fall;
    logic [OUT_W-1:0] po_cnt;
    logic             busy;

    modport master (
        output en, div_n, div_load,
        input  div_ack, div_err, clk_out, ce_rise, ce_fall, po_cnt, busy
    );

    modport slave (
        input  en, div_n, div_load,
        output div_ack, div_err, clk_out, ce_rise, ce_fall, po_cnt, busy
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider producing a registered divided clock plus
// rise/fall clock-enable pulses, with glitch-free ratio changes.
// Ports: clk, rst (sync, active-high), bus (clk_div_prog_if.slave):
//   en, div_n, div_load in; div_ack, div_err, clk_out, ce_rise, ce_fall,
//   po_cnt, busy out (all registered).
module clk_div_prog #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned OUT_W = 2,
    parameter int unsigned DEF_N = 4
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);
    localparam int unsigned LW = CNT_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] div_cnt_q,  div_cnt_d;
    logic [CNT_W-1:0] n_act_q,    n_act_d;
    logic [CNT_W-1:0] pend_n_q,   pend_n_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q,  clk_out_d;
    logic             ce_rise_q,  ce_rise_d;
    logic             ce_fall_q,  ce_fall_d;
    logic             div_ack_q,  div_ack_d;
    logic             div_err_q,  div_err_d;
    logic             busy_q,     busy_d;
    logic [OUT_W-1:0] po_cnt_q,   po_cnt_d;

    logic             load_ok_c;
    logic             wrap_c;
    logic             run_c;
    logic [LW-1:0]    half_c;

    // Next-state, ratio handling and output decode
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        n_act_d    = n_act_q;
        pend_n_d   = pend_n_q;
        pend_vld_d = pend_vld_q;
        div_ack_d  = 1'b0;
        div_err_d  = 1'b0;

        load_ok_c = bus.div_load && (bus.div_n >= CNT_W'(2));
        wrap_c    = (state_q != ST_IDLE) && (div_cnt_q == n_act_q - CNT_W'(1));

        case (state_q)
            ST_IDLE: if (bus.en) state_d = ST_RUN;
            ST_RUN:  if (!bus.en) state_d = wrap_c ? ST_IDLE : ST_STOP;
            ST_STOP: begin
                if (bus.en)      state_d = ST_RUN;
                else if (wrap_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.div_load && !load_ok_c) div_err_d = 1'b1;

        // Idle: ratio takes effect at once. Running: only at a period boundary.
        // A pending value left over from a load on the final wrap is applied here.
        if (state_q == ST_IDLE) begin
            if (load_ok_c) begin
                n_act_d   = bus.div_n;
                div_ack_d = 1'b1;
            end else if (pend_vld_q) begin
                n_act_d    = pend_n_q;
                pend_vld_d = 1'b0;
                div_ack_d  = 1'b1;
            end
        end else begin
            if (wrap_c && pend_vld_q) begin
                n_act_d    = pend_n_q;
                pend_vld_d = 1'b0;
                div_ack_d  = 1'b1;
            end
            // A load on the wrap cycle only becomes pending for the next wrap
            if (load_ok_c) begin
                pend_n_d   = bus.div_n;
                pend_vld_d = 1'b1;
            end
        end

        if (state_q == ST_IDLE || state_d == ST_IDLE || wrap_c)
            div_cnt_d = '0;
        else
            div_cnt_d = div_cnt_q + CNT_W'(1);

        // Outputs are decoded from next-cycle count so they align with div_cnt_q
        run_c     = (state_d != ST_IDLE);
        half_c    = LW'(n_act_d >> 1) + LW'(n_act_d[0]);
        clk_out_d = run_c && (LW'(div_cnt_d) >= half_c);
        ce_rise_d = run_c && (LW'(div_cnt_d) == half_c);
        ce_fall_d = wrap_c;
        busy_d    = run_c;
        po_cnt_d  = po_cnt_q + OUT_W'(ce_rise_q);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            n_act_q    <= CNT_W'(DEF_N);
            pend_n_q   <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            ce_rise_q  <= 1'b0;
            ce_fall_q  <= 1'b0;
            div_ack_q  <= 1'b0;
            div_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            po_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            n_act_q    <= n_act_d;
            pend_n_q   <= pend_n_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            ce_rise_q  <= ce_rise_d;
            ce_fall_q  <= ce_fall_d;
            div_ack_q  <= div_ack_d;
            div_err_q  <= div_err_d;
            busy_q     <= busy_d;
            po_cnt_q   <= po_cnt_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.ce_rise = ce_rise_q;
    assign bus.ce_fall = ce_fall_q;
    assign bus.div_ack = div_ack_q;
    assign bus.div_err = div_err_q;
    assign bus.busy    = busy_q;
    assign bus.po_cnt  = po_cnt_q;
endmodule
